mem_responder: RTL and testbench

Memory-side responder for the core's data/instruction memory port. It accepts one load or store request at a time over a valid/ready request channel, inserts a configurable number of wait states, then returns a response on a valid/ready response channel. It lets the multicycle control FSM run against realistic memory latency instead of a zero-latency array. Word-aligned, byte-enabled, with an error response for bad addresses.

---
 rtl/mem_responder_pkg.sv | 19 +
 rtl/mem_array.sv | 34 +++
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder and its storage array.
package mem_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  be_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // A request is rejected when it is not word aligned or falls past the end of memory.
    function automatic logic addr_err(input addr_t addr, input int unsigned mem_size);
        return (addr[1:0] != 2'b00) || (addr >= addr_t'(mem_size));
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with per-byte write enables and a registered read port.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  data_t         wdata,
    input  be_t           be,
    output data_t         rdata
);

    // One independent byte-wide RAM per lane keeps each array single-driver.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rdata_q;

        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                lane_mem[addr] <= wdata[8*gi +: 8];
            end
            if (re) begin
                lane_rdata_q <= lane_mem[addr];
            end
        end

        assign rdata[8*gi +: 8] = lane_rdata_q;
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder: request latch, wait-state counter,
// address check and a registered response channel in front of mem_array.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_SIZE    = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  req_valid,
    output logic  req_ready,
    input  logic  req_write,
    input  addr_t req_addr,
    input  data_t req_wdata,
    input  be_t   req_be,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output data_t rsp_rdata,
    output logic  rsp_err
);

    localparam int DEPTH = MEM_SIZE / 4;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    mem_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    addr_t      addr_q, addr_d;
    data_t      wdata_q, wdata_d;
    be_t        be_q, be_d;
    logic       req_ready_q, req_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    data_t      rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;

    logic  acc_go;
    logic  acc_write;
    addr_t acc_addr;
    data_t acc_wdata;
    be_t   acc_be;
    logic  acc_err;
    data_t mem_rdata;

    // With zero wait states the access happens on the accept edge, straight from the inputs.
    always_comb begin
        acc_write = write_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
        acc_err = addr_err(acc_addr, MEM_SIZE);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        acc_go      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    if (WAIT_CYCLES == 0) begin
                        acc_go  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_go  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // First RESP cycle waits for the synchronous read, then the response is held.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = addr_err(addr_q, MEM_SIZE);
                    rsp_rdata_d = (write_q || addr_err(addr_q, MEM_SIZE)) ? '0 : mem_rdata;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    mem_array #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem_array (
        .clk  (clk),
        .we   (acc_go && acc_write && !acc_err),
        .re   (acc_go && !acc_write && !acc_err),
        .addr (acc_addr[AW+1:2]),
        .wdata(acc_wdata),
        .be   (acc_be),
        .rdata(mem_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (1, 0 and 4 wait states) sharing clock and reset.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_checks = 0;
    int n_fail   = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_responder #(
            .MEM_SIZE   (1024),
            .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 0 : 4))
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid[gi]),
            .req_ready(req_ready[gi]),
            .req_write(req_write[gi]),
            .req_addr (req_addr[gi]),
            .req_wdata(req_wdata[gi]),
            .req_be   (req_be[gi]),
            .rsp_valid(rsp_valid[gi]),
            .rsp_ready(rsp_ready[gi]),
            .rsp_rdata(rsp_rdata[gi]),
            .rsp_err  (rsp_err[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete request/response; hold > 0 keeps rsp_ready low for that many RESP cycles
    // while a competing request is offered.
    task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic e, output int lat);
        int guard;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) check("ready_timeout", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        rsp_ready[d] = (hold == 0);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) check("rsp_timeout", 32'(rsp_valid[d]), 32'd1);
        rd = rsp_rdata[d];
        e  = rsp_err[d];
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = 1'b1;
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid[d]), 32'd1);
            check("bp_rdata", rsp_rdata[d], rd);
            check("bp_err", 32'(rsp_err[d]), 32'(e));
            check("bp_req_ready", 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check("ready_after_rsp", 32'(req_ready[d]), 32'd1);
        check("valid_after_rsp", 32'(rsp_valid[d]), 32'd0);
        $display("txn dut%0d %s addr=0x%08h wdata=0x%08h be=0x%h -> rdata=0x%08h err=%0d lat=%0d",
                 d, wr ? "ST" : "LD", a, wd, be, rd, e, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;

        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            rsp_ready[i] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(req_ready[0]), 32'd1);

        // Store then load, one wait state.
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e, lat);
        check("st_err", 32'(e), 32'd0);
        check("st_rdata", rd, 32'd0);
        check("st_lat", 32'(lat), 32'd2);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
        check("ld_rdata", rd, 32'hDEADBEEF);
        check("ld_err", 32'(e), 32'd0);
        check("ld_lat", 32'(lat), 32'd2);

        // Byte-enable merge.
        txn(0, 1'b1, 32'h10, 32'h11223344, 4'h5, 0, rd, e, lat);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
        check("be_merge", rd, 32'hDE22BE44);

        // Misaligned load.
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0, rd, e, lat);
        check("misalign_err", 32'(e), 32'd1);
        check("misalign_rdata", rd, 32'd0);

        // Out-of-range store must leave the last word and word 0 untouched.
        txn(0, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 0, rd, e, lat);
        txn(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 0, rd, e, lat);
        txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, rd, e, lat);
        check("oor_err", 32'(e), 32'd1);
        check("oor_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, e, lat);
        check("oor_last_word", rd, 32'h0BADF00D);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, e, lat);
        check("oor_word0", rd, 32'h12345678);

        // Store with no byte enables is a successful no-op.
        txn(0, 1'b1, 32'h10, 32'h99999999, 4'h0, 0, rd, e, lat);
        check("be0_err", 32'(e), 32'd0);

        // Backpressure: response held five cycles, second request ignored.
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, e, lat);
        check("bp_load", rd, 32'hDE22BE44);

        // Zero and four wait states.
        txn(1, 1'b1, 32'h40, 32'hA5A55A5A, 4'hF, 0, rd, e, lat);
        check("w0_st_lat", 32'(lat), 32'd1);
        txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, e, lat);
        check("w0_ld_lat", 32'(lat), 32'd1);
        check("w0_ld_rdata", rd, 32'hA5A55A5A);
        txn(2, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, e, lat);
        check("w4_st_lat", 32'(lat), 32'd5);

        // Reset in the middle of a store's wait states.
        req_valid[2] = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'hFFFFFFFF;
        req_be[2]    = 4'hF;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        check("mid_wait_ready", 32'(req_ready[2]), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready0", 32'(req_ready[0]), 32'd0);
        check("async_rst_ready1", 32'(req_ready[1]), 32'd0);
        check("async_rst_valid2", 32'(rsp_valid[2]), 32'd0);
        check("async_rst_rdata2", rsp_rdata[2], 32'd0);
        check("async_rst_err2", 32'(rsp_err[2]), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("rel_ready2", 32'(req_ready[2]), 32'd1);
        txn(2, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat);
        check("dropped_store", rd, 32'hCAFEF00D);
        check("w4_ld_lat", 32'(lat), 32'd5);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
        check("mem_kept_reset", rd, 32'hDE22BE44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
